tl_source_inflight_tracker: RTL



---
 rtl/tl_source_inflight_tracker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tl_source_inflight_tracker.sv
// Per-source in-flight tracker for a TileLink edge: A/D matching, source reuse and watchdog checks.
// Optional per-source opcode check is compiled in with `define TL_TRACKER_OPCODE_CHECK_EN.
module tl_source_inflight_tracker #(
  parameter int SRC_W   = 4,
  parameter int TIMEOUT = 1024,
  parameter int WD_W    = 11
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_fire,
  input  logic                    a_first,
  input  logic [SRC_W-1:0]        a_source,
  input  logic [2:0]              a_opcode,
  input  logic                    d_fire,
  input  logic                    d_first,
  input  logic                    d_last,
  input  logic [SRC_W-1:0]        d_source,
  input  logic [2:0]              d_opcode,
  output logic                    chk_a_valid,
  output logic                    chk_a_ok,
  output logic                    chk_d_valid,
  output logic                    chk_d_ok,
  output logic                    chk_op_valid,
  output logic                    chk_op_ok,
  output logic                    chk_wd_valid,
  output logic                    chk_wd_ok,
  output logic [(1<<SRC_W)-1:0]   inflight,
  output logic                    idle
);

  localparam int NUM_SRC = 1 << SRC_W;

  logic [NUM_SRC-1:0] r_inflight;
  logic [NUM_SRC-1:0] w_a_set;
  logic [NUM_SRC-1:0] w_d_clr;
  logic               w_a_evt;
  logic               w_d_evt;
  logic               w_d_end;
  logic               w_a_ok;
  logic               w_d_hit;
  logic               w_wd_expire;

  logic r_chk_a_valid, r_chk_a_ok;
  logic r_chk_d_valid, r_chk_d_ok;
  logic r_chk_wd_valid, r_chk_wd_ok;

  assign w_a_evt = a_fire & a_first;
  assign w_d_evt = d_fire & d_first;
  assign w_d_end = d_fire & d_last;

  always_comb begin
    w_a_set = '0;
    w_d_clr = '0;
    if (w_a_evt) w_a_set[a_source] = 1'b1;
    if (w_d_end) w_d_clr[d_source] = 1'b1;
  end

  // A response retiring the same source in this cycle makes the reuse legal.
  assign w_a_ok  = ~r_inflight[a_source] | (w_d_end & (d_source == a_source));
  assign w_d_hit = r_inflight[d_source];

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inflight     <= '0;
      r_chk_a_valid  <= 1'b0;
      r_chk_a_ok     <= 1'b1;
      r_chk_d_valid  <= 1'b0;
      r_chk_d_ok     <= 1'b1;
      r_chk_wd_valid <= 1'b0;
      r_chk_wd_ok    <= 1'b1;
    end else begin
      r_inflight     <= (r_inflight & ~w_d_clr) | w_a_set;
      r_chk_a_valid  <= w_a_evt;
      r_chk_a_ok     <= ~w_a_evt | w_a_ok;
      r_chk_d_valid  <= w_d_evt;
      r_chk_d_ok     <= ~w_d_evt | w_d_hit;
      r_chk_wd_valid <= w_wd_expire;
      r_chk_wd_ok    <= ~w_wd_expire;
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_no_wd
      assign w_wd_expire = 1'b0;
    end else begin : g_wd
      logic [WD_W-1:0] r_wd_cnt;
      logic            w_wd_inc;

      assign w_wd_inc    = (|r_inflight) & ~a_fire & ~d_fire;
      assign w_wd_expire = w_wd_inc & (r_wd_cnt == WD_W'(TIMEOUT - 1));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_wd_cnt <= '0;
        end else if (!w_wd_inc || w_wd_expire) begin
          r_wd_cnt <= '0;
        end else begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
      end
    end
  endgenerate

`ifdef TL_TRACKER_OPCODE_CHECK_EN
  logic [2:0] r_op_ram [NUM_SRC];
  logic       r_chk_op_valid, r_chk_op_ok;
  logic       w_op_match;

  function automatic logic f_op_match(input logic [2:0] a_op, input logic [2:0] d_op);
    logic ok;
    ok = 1'b0;
    case (a_op)
      3'd0, 3'd1: ok = (d_op == 3'd0);
      3'd2, 3'd3: ok = (d_op == 3'd1);
      3'd4:       ok = (d_op == 3'd1);
      3'd5:       ok = (d_op == 3'd2);
      default:    ok = (d_op == 3'd4) || (d_op == 3'd5);
    endcase
    return ok;
  endfunction

  // NOTE: the opcode RAM has no reset; an entry is only read while its inflight bit, which is reset, is set.
  always_ff @(posedge clock) begin
    if (w_a_evt) r_op_ram[a_source] <= a_opcode;
  end

  // Unmatched D already fails the D check, so the opcode check stays quiet for it.
  assign w_op_match = ~w_d_hit | f_op_match(r_op_ram[d_source], d_opcode);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_chk_op_valid <= 1'b0;
      r_chk_op_ok    <= 1'b1;
    end else begin
      r_chk_op_valid <= w_d_evt;
      r_chk_op_ok    <= ~w_d_evt | w_op_match;
    end
  end

  assign chk_op_valid = r_chk_op_valid;
  assign chk_op_ok    = r_chk_op_ok;
`else
  logic w_unused_opcodes;
  assign w_unused_opcodes = ^{a_opcode, d_opcode};
  assign chk_op_valid     = 1'b0;
  assign chk_op_ok        = 1'b1;
`endif

  assign chk_a_valid  = r_chk_a_valid;
  assign chk_a_ok     = r_chk_a_ok;
  assign chk_d_valid  = r_chk_d_valid;
  assign chk_d_ok     = r_chk_d_ok;
  assign chk_wd_valid = r_chk_wd_valid;
  assign chk_wd_ok    = r_chk_wd_ok;
  assign inflight     = r_inflight;
  assign idle         = ~|r_inflight;

endmodule
